// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if
//   Bundles the buses around the register-file write-port controller.
//   master : write-back sources, scoreboard user and register file
//            (drive requests and queries, observe grants and the write port)
//   slave  : rf_wb_arbiter
//   Signals:
//     a_valid/a_rd/a_data, a_stall         pipeline write-back (priority source)
//     b_valid/b_rd/b_data, b_ready         multi-cycle unit result handshake
//     rf_we/rf_rd/rf_din                   register-file write port
//     q_rs1/q_rs2, q_busy1/q_busy2         scoreboard lookup on pending B writes
//     init_done                            clear sequence complete
interface rf_wb_arbiter_if;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        a_stall;

    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_rd;
    logic [31:0] b_data;

    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_din;

    logic [4:0]  q_rs1;
    logic [4:0]  q_rs2;
    logic        q_busy1;
    logic        q_busy2;

    logic        init_done;

    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data, q_rs1, q_rs2,
        input  a_stall, b_ready, rf_we, rf_rd, rf_din, q_busy1, q_busy2, init_done
    );

    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data, q_rs1, q_rs2,
        output a_stall, b_ready, rf_we, rf_rd, rf_din, q_busy1, q_busy2, init_done
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Controller for the single write port of the 32x32 register file.
//   - Optional clear sequence (macro RF_INIT_SEQ_EN): after reset release,
//     32 cycles write x0..x31 with zero, x2 gets SP_INIT. Without the macro
//     the block comes out of reset ready to arbitrate.
//   - Arbitration: pipeline write-back A has priority; results of the
//     multi-cycle unit B are buffered in a 2-entry in-order FIFO. A starve
//     counter forces the FIFO head through after STARVE_MAX blocked cycles.
//   - Writes to x0 are dropped (A consumed without a write, B not enqueued).
//   - Scoreboard: q_busy* flags a query matching any valid FIFO entry.
//   Ports:
//     clk    sole clock, rising edge
//     reset  asynchronous, active-low
//     bus    rf_wb_arbiter_if.slave (A/B requests, RF write port, queries)
//   Parameters:
//     STARVE_MAX  blocked cycles before B is forced (1..15)
//     SP_INIT     x2 value of the clear sequence (RF_INIT_SEQ_EN builds only)
module rf_wb_arbiter #(
    parameter int STARVE_MAX = 4
`ifdef RF_INIT_SEQ_EN
    , parameter logic [31:0] SP_INIT = 32'h2ffc
`endif
) (
    input  logic             clk,
    input  logic             reset,
    rf_wb_arbiter_if.slave   bus
);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_ent_t;

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    // FIFO storage, pointer-based so pop never moves data
    wb_ent_t [1:0] fifo_q;
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic [3:0]    starve;

    logic          run;
    logic          fifo_ne;
    logic          force_b;
    logic          a_wr;
    logic          grant_a;
    logic          grant_b;
    logic          push;
    wb_ent_t       head;

    logic          we_c;
    logic [4:0]    rd_c;
    logic [31:0]   din_c;

    // ------------------------------------------------------------------
    // Init / run control
    // ------------------------------------------------------------------
`ifdef RF_INIT_SEQ_EN
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic        init_done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_INIT;
            cnt         <= 5'd0;
            init_done_q <= 1'b0;
        end else if (state == ST_INIT) begin
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
                state       <= ST_RUN;
                init_done_q <= 1'b1;
            end
        end
    end

    assign run           = (state == ST_RUN);
    assign bus.init_done = init_done_q;
`else
    assign run           = 1'b1;
    assign bus.init_done = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign fifo_ne = (count != 2'd0);
    assign head    = fifo_q[rd_ptr];
    assign a_wr    = bus.a_valid && (bus.a_rd != 5'd0);
    assign force_b = run && fifo_ne && (starve == SMAX);
    // A to x0 leaves the port free, so the FIFO may drain that cycle
    assign grant_b = run && fifo_ne && (force_b || !a_wr);
    assign grant_a = run && a_wr && !force_b;

    // b_ready looks only at registered count: no same-cycle pop bypass
    assign bus.b_ready = run && (count != 2'd2);
    assign bus.a_stall = !run || force_b;
    assign push        = bus.b_valid && bus.b_ready && (bus.b_rd != 5'd0);

    // Write port mux; held quiet while reset is asserted
    always_comb begin
        we_c  = 1'b0;
        rd_c  = 5'd0;
        din_c = 32'd0;
        if (reset) begin
`ifdef RF_INIT_SEQ_EN
            if (state == ST_INIT) begin
                we_c  = 1'b1;
                rd_c  = cnt;
                din_c = (cnt == 5'd2) ? SP_INIT : 32'd0;
            end else
`endif
            if (grant_b) begin
                we_c  = 1'b1;
                rd_c  = head.rd;
                din_c = head.data;
            end else if (grant_a) begin
                we_c  = 1'b1;
                rd_c  = bus.a_rd;
                din_c = bus.a_data;
            end
        end
    end

    assign bus.rf_we  = we_c;
    assign bus.rf_rd  = rd_c;
    assign bus.rf_din = din_c;

    // ------------------------------------------------------------------
    // FIFO and starve counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_q <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            starve <= 4'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr] <= '{rd: bus.b_rd, data: bus.b_data};
                wr_ptr         <= ~wr_ptr;
            end
            if (grant_b)
                rd_ptr <= ~rd_ptr;
            case ({push, grant_b})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (!fifo_ne || grant_b)
                starve <= 4'd0;
            else if (starve != SMAX)
                starve <= starve + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: valid entries include one being popped this cycle
    // ------------------------------------------------------------------
    logic [1:0]      ent_vld;
    logic [1:0][4:0] q_rs;
    logic [1:0]      q_busy;

    always_comb begin
        ent_vld = 2'b00;
        for (int i = 0; i < 2; i++)
            ent_vld[i] = (count == 2'd2) || ((count == 2'd1) && (rd_ptr == 1'(i)));
    end

    assign q_rs = {bus.q_rs2, bus.q_rs1};

    for (genvar p = 0; p < 2; p++) begin : g_query
        logic [1:0] hit;
        for (genvar e = 0; e < 2; e++) begin : g_ent
            assign hit[e] = ent_vld[e] && (fifo_q[e].rd == q_rs[p]);
        end
        assign q_busy[p] = (q_rs[p] != 5'd0) && (|hit);
    end

    assign bus.q_busy1 = q_busy[0];
    assign bus.q_busy2 = q_busy[1];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

    localparam int SMAX = 4;
`ifdef RF_INIT_SEQ_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rf_wb_arbiter_if bus();

    rf_wb_arbiter #(.STARVE_MAX(SMAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    // Reference model state
    ent_t mq[$];
    int   starve;
    bit   in_init;
    int   icnt;
    bit   last_stall;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs already driven; check at negedge, advance model, go to posedge+1
    task automatic step();
        bit          e_we, e_stall, e_bready, e_done, e_b1, e_b2, gb;
        logic [4:0]  e_rd;
        logic [31:0] e_din;
        e_we = 0; e_rd = 0; e_din = 0; e_stall = 0; e_bready = 0; e_done = 0;
        e_b1 = 0; e_b2 = 0; gb = 0;
        @(negedge clk);
        if (in_init) begin
            e_we = 1; e_rd = 5'(icnt); e_din = (icnt == 2) ? 32'h2ffc : 32'd0;
            e_stall = 1; e_bready = 0; e_done = 0;
        end else begin
            e_done   = 1;
            e_bready = (mq.size() < 2);
            if (mq.size() != 0 && starve == SMAX) begin
                gb = 1; e_stall = 1;
            end else if (bus.a_valid && bus.a_rd != 0) begin
                e_we = 1; e_rd = bus.a_rd; e_din = bus.a_data;
            end else if (mq.size() != 0) begin
                gb = 1;
            end
            if (gb) begin
                e_we = 1; e_rd = mq[0].rd; e_din = mq[0].data;
            end
            foreach (mq[i]) begin
                if (bus.q_rs1 != 0 && mq[i].rd == bus.q_rs1) e_b1 = 1;
                if (bus.q_rs2 != 0 && mq[i].rd == bus.q_rs2) e_b2 = 1;
            end
        end
        chk("rf_we",     bus.rf_we,     e_we);
        chk("rf_rd",     bus.rf_rd,     e_rd);
        chk("rf_din",    bus.rf_din,    e_din);
        chk("a_stall",   bus.a_stall,   e_stall);
        chk("b_ready",   bus.b_ready,   e_bready);
        chk("init_done", bus.init_done, e_done);
        chk("q_busy1",   bus.q_busy1,   e_b1);
        chk("q_busy2",   bus.q_busy2,   e_b2);
        if (in_init) begin
            icnt++;
            if (icnt == 32) in_init = 0;
        end else begin
            if (mq.size() == 0 || gb) starve = 0;
            else if (starve < SMAX) starve++;
            if (gb) void'(mq.pop_front());
            if (bus.b_valid && e_bready && bus.b_rd != 0)
                mq.push_back('{rd: bus.b_rd, data: bus.b_data});
        end
        last_stall = e_stall;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.a_valid = 0; bus.a_rd = 0; bus.a_data = 0;
        bus.b_valid = 0; bus.b_rd = 0; bus.b_data = 0;
        bus.q_rs1 = 0; bus.q_rs2 = 0;
    endtask

    // Assert reset, check the asynchronous reset state, release after one edge
    task automatic reset_dut(input string tag);
        reset = 1'b0;
        #1;
        chk({tag, "_we"},    bus.rf_we,     1'b0);
        chk({tag, "_rd"},    bus.rf_rd,     5'd0);
        chk({tag, "_din"},   bus.rf_din,    32'd0);
        chk({tag, "_busy1"}, bus.q_busy1,   1'b0);
        chk({tag, "_stall"}, bus.a_stall,   INIT_EN);
        chk({tag, "_bry"},   bus.b_ready,   !INIT_EN);
        chk({tag, "_done"},  bus.init_done, !INIT_EN);
        mq.delete();
        starve = 0; icnt = 0; in_init = INIT_EN; last_stall = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        idle_inputs();
        #2;
        // Requests during reset must not reach the write port
        bus.a_valid = 1; bus.a_rd = 5'd7; bus.a_data = 32'hdead;
        bus.q_rs1 = 5'd3;
        reset_dut("rst0");

        // Clear sequence (or first RUN cycles): requests present but ignored in INIT
        bus.a_valid = 1; bus.a_rd = 5'd3; bus.a_data = 32'h33;
        bus.b_valid = 1; bus.b_rd = 5'd4; bus.b_data = 32'h44;
        if (in_init) begin
            for (int i = 0; i < 32; i++) step();
        end
        idle_inputs();
        step();

        // Back-to-back B with A idle
        bus.b_valid = 1; bus.b_rd = 5'd5; bus.b_data = 32'h11; step();
        bus.b_rd = 5'd6; bus.b_data = 32'h22; step();
        bus.b_valid = 0; step(); step();

        // A every cycle, two B entries queued, starve forcing
        bus.a_valid = 1; bus.a_rd = 5'd7; bus.a_data = 32'h77;
        bus.b_valid = 1; bus.b_rd = 5'd10; bus.b_data = 32'ha0; step();
        bus.b_rd = 5'd11; bus.b_data = 32'hb0; step();
        bus.b_valid = 0;
        for (int i = 0; i < 12; i++) step();
        idle_inputs(); step();

        // Scoreboard while the entry is held back by A
        bus.a_valid = 1; bus.a_rd = 5'd8; bus.a_data = 32'h88;
        bus.b_valid = 1; bus.b_rd = 5'd9; bus.b_data = 32'h99;
        bus.q_rs1 = 5'd9; bus.q_rs2 = 5'd0; step();
        bus.b_valid = 0;
        for (int i = 0; i < 7; i++) step();

        // B to x0 dropped; A to x0 lets the FIFO drain
        idle_inputs();
        bus.b_valid = 1; bus.b_rd = 5'd0; bus.b_data = 32'hff; bus.q_rs2 = 5'd0; step();
        bus.b_valid = 0; step();
        bus.a_valid = 1; bus.a_rd = 5'd12; bus.a_data = 32'hc0;
        bus.b_valid = 1; bus.b_rd = 5'd13; bus.b_data = 32'hd0; step();
        bus.b_valid = 0; bus.a_rd = 5'd0; bus.q_rs1 = 5'd13; step(); step();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            if (!(last_stall && bus.a_valid)) begin
                bus.a_valid = 1'($urandom_range(0, 1));
                bus.a_rd    = 5'($urandom_range(0, 7));
                bus.a_data  = $urandom;
            end
            bus.b_valid = 1'($urandom_range(0, 1));
            bus.b_rd    = 5'($urandom_range(0, 7));
            bus.b_data  = $urandom;
            bus.q_rs1   = 5'($urandom_range(0, 7));
            bus.q_rs2   = 5'($urandom_range(0, 7));
            step();
        end

        // Reset with the FIFO full
        idle_inputs();
        bus.a_valid = 1; bus.a_rd = 5'd7; bus.a_data = 32'h70;
        bus.b_valid = 1; bus.b_rd = 5'd14; bus.b_data = 32'he0; step();
        bus.b_rd = 5'd15; bus.b_data = 32'hf0; step();
        bus.b_valid = 0; bus.q_rs1 = 5'd14; step();
        reset_dut("rst1");
        idle_inputs();
        for (int i = 0; i < 34; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
